mcycle_sequencer: RTL and testbench

- Control FSM for the iterative multiply/divide datapath of the ARM processor core.
- Accepts a start request from the decoder, stalls the pipeline via Busy, and sequences operand load, WIDTH shift/add (or shift/subtract) steps and an optional signed fix-up.
- Reports completion to the datapath and hazard logic.
- Holds no operand or result data. It issues control strobes only, alongside the existing CondLogic/Decoder control path.

---
 rtl/mcycle_pkg.sv | 19 +
 rtl/mcycle_iter_counter.sv | 41 ++++
 rtl/mcycle_sequencer.sv | 125 ++++++++++++
 tb/tb_mcycle_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
// No logic: state encoding and operation codes only.
// Imported by the sequencer top and its iteration counter.
package mcycle_pkg;

  // FSM state encoding
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mcycle_state_e;

  // MCycleOp encoding
  localparam logic MCYCLE_MUL = 1'b0;
  localparam logic MCYCLE_DIV = 1'b1;

endpackage

// File: rtl/mcycle_iter_counter.sv
// Iteration counter for the multiply/divide step sequence, with terminal flag.
// Latency: Count updates one cycle after Clear/Enable; Last is combinational from Count.
// Backpressure: none; Clear has priority over Enable, wraps to 0 after WIDTH-1.
module mcycle_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Clear,
  input  logic             Enable,
  output logic [CNT_W-1:0] Count,
  output logic             Last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count: clear wins, otherwise increment (power-of-two width wraps naturally)
  always_comb begin
    count_d = count_q;
    if (Clear) begin
      count_d = '0;
    end else if (Enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;
  assign Last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mcycle_sequencer.sv
// Control FSM sequencing load, WIDTH iteration steps and optional sign fix-up for mul/div.
// Latency: Done at WIDTH+2 cycles after acceptance (WIDTH+3 signed, 2 on divide-by-zero).
// Backpressure: Busy stalls the pipeline from the acceptance cycle; new Start taken only in IDLE.
module mcycle_sequencer
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic             DivisorZero,
  output logic             Busy,
  output logic             Load,
  output logic             Step,
  output logic             Negate,
  output logic             Done,
  output logic             DivZero,
  output logic             OpLatched,
  output logic             SignedLatched,
  output logic [CNT_W-1:0] Count
);

  mcycle_state_e state_q, state_d;
  logic          op_q, op_d;
  logic          sgn_q, sgn_d;
  logic          dz_q, dz_d;
  logic          cnt_clr;
  logic          cnt_en;
  logic          cnt_last;

  mcycle_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK    (CLK),
    .RESET  (RESET),
    .Clear  (cnt_clr),
    .Enable (cnt_en),
    .Count  (Count),
    .Last   (cnt_last)
  );

  // next-state and control strobes; only Busy-in-IDLE looks at a live input
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    dz_d    = dz_q;
    Busy    = 1'b0;
    Load    = 1'b0;
    Step    = 1'b0;
    Negate  = 1'b0;
    Done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // stall must land in the acceptance cycle; masked so reset forces it low
        Busy = Start & ~RESET;
        if (Start) begin
          op_d    = MCycleOp;
          sgn_d   = Signed;
          dz_d    = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        Load    = 1'b1;
        Busy    = 1'b1;
        cnt_clr = 1'b1;
        if ((op_q == MCYCLE_DIV) && DivisorZero) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        Step   = 1'b1;
        Busy   = 1'b1;
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = sgn_q ? FIX : DONE;
        end
      end
      FIX: begin
        Negate  = 1'b1;
        Busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        // Start here is still the finishing instruction's request; do not re-accept
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and per-operation latches
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
    end
  end

  assign DivZero       = dz_q;
  assign OpLatched     = op_q;
  assign SignedLatched = sgn_q;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Directed bench for mcycle_sequencer: reset, mul/div sequences, abort, mid-op reset, back-to-back.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Expected strobes come from the documented cycle-by-cycle latency table.
module tb_mcycle_sequencer;

  localparam int W  = 32;
  localparam int CW = $clog2(W);

  logic          CLK;
  logic          RESET;
  logic          Start;
  logic          MCycleOp;
  logic          Signed;
  logic          DivisorZero;
  logic          Busy;
  logic          Load;
  logic          Step;
  logic          Negate;
  logic          Done;
  logic          DivZero;
  logic          OpLatched;
  logic          SignedLatched;
  logic [CW-1:0] Count;

  int checks = 0;
  int errors = 0;

  mcycle_sequencer #(.WIDTH(W)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .Start         (Start),
    .MCycleOp      (MCycleOp),
    .Signed        (Signed),
    .DivisorZero   (DivisorZero),
    .Busy          (Busy),
    .Load          (Load),
    .Step          (Step),
    .Negate        (Negate),
    .Done          (Done),
    .DivZero       (DivZero),
    .OpLatched     (OpLatched),
    .SignedLatched (SignedLatched),
    .Count         (Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Load/Step/Negate/Done must be one-hot-or-zero in every cycle
  always @(negedge CLK) begin
    checks++;
    if ($countones({Load, Step, Negate, Done}) > 1) begin
      errors++;
      $display("FAIL onehot t=%0t got=%b required at most one set", $time, {Load, Step, Negate, Done});
    end
  end

  // expected {Busy,Load,Step,Negate,Done} for cycle c after acceptance
  function automatic logic [4:0] exp_ctl(input int c, input bit sgn, input bit abort);
    int done_c;
    if (abort) done_c = 2;
    else       done_c = sgn ? W + 3 : W + 2;
    if (c == 0)                               return 5'b10000;
    if (c == 1)                               return 5'b11000;
    if (!abort && c >= 2 && c <= W + 1)       return 5'b10100;
    if (!abort && sgn && c == W + 2)          return 5'b10010;
    if (c == done_c)                          return 5'b00001;
    return 5'b00000;
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int c, input bit abort);
    if (!abort && c >= 2 && c <= W + 1) return CW'(c - 2);
    return '0;
  endfunction

  task automatic drive_cycle(input logic st, input logic op, input logic sg, input logic dz);
    @(posedge CLK);
    #1;
    Start       = st;
    MCycleOp    = op;
    Signed      = sg;
    DivisorZero = dz;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; Start = 1'b1; MCycleOp = 1'b1; Signed = 1'b1; DivisorZero = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Busy, Load, Step, Negate, Done, DivZero, OpLatched, SignedLatched} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=00000000",
               {Busy, Load, Step, Negate, Done, DivZero, OpLatched, SignedLatched});
    end
    checks++;
    if (Count !== '0) begin
      errors++;
      $display("FAIL reset_count got=%0d required=0", Count);
    end
    Start = 1'b0; MCycleOp = 1'b0; Signed = 1'b0; DivisorZero = 1'b0;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if ({Busy, Load, Step, Negate, Done} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset got=%b required=00000", {Busy, Load, Step, Negate, Done});
    end
  endtask

  // unsigned multiply with DivisorZero high throughout (must be ignored for mul)
  task automatic test_unsigned_mul();
    for (int c = 0; c <= W + 3; c++) begin
      drive_cycle(c <= W + 2, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({Busy, Load, Step, Negate, Done} !== exp_ctl(c, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL umul_ctl cyc=%0d got=%b required=%b", c, {Busy, Load, Step, Negate, Done}, exp_ctl(c, 1'b0, 1'b0));
      end
      checks++;
      if (Count !== exp_cnt(c, 1'b0)) begin
        errors++;
        $display("FAIL umul_count cyc=%0d got=%0d required=%0d", c, Count, exp_cnt(c, 1'b0));
      end
      if (c >= 1) begin
        checks++;
        if ({OpLatched, SignedLatched} !== 2'b00) begin
          errors++;
          $display("FAIL umul_latched cyc=%0d got=%b required=00", c, {OpLatched, SignedLatched});
        end
      end
      if (c == W + 2) begin
        checks++;
        if (DivZero !== 1'b0) begin
          errors++;
          $display("FAIL umul_divzero got=%b required=0", DivZero);
        end
      end
    end
  endtask

  // signed divide; DivisorZero high everywhere except LOAD (must be ignored)
  task automatic test_signed_div();
    for (int c = 0; c <= W + 4; c++) begin
      drive_cycle(c <= W + 3, 1'b1, 1'b1, c != 1);
      checks++;
      if ({Busy, Load, Step, Negate, Done} !== exp_ctl(c, 1'b1, 1'b0)) begin
        errors++;
        $display("FAIL sdiv_ctl cyc=%0d got=%b required=%b", c, {Busy, Load, Step, Negate, Done}, exp_ctl(c, 1'b1, 1'b0));
      end
      checks++;
      if (Count !== exp_cnt(c, 1'b0)) begin
        errors++;
        $display("FAIL sdiv_count cyc=%0d got=%0d required=%0d", c, Count, exp_cnt(c, 1'b0));
      end
      if (c >= 1) begin
        checks++;
        if ({OpLatched, SignedLatched} !== 2'b11) begin
          errors++;
          $display("FAIL sdiv_latched cyc=%0d got=%b required=11", c, {OpLatched, SignedLatched});
        end
      end
      if (c == W + 3) begin
        checks++;
        if (DivZero !== 1'b0) begin
          errors++;
          $display("FAIL sdiv_divzero got=%b required=0", DivZero);
        end
      end
    end
  endtask

  // signed divide by zero: abort straight from LOAD, no Step/Negate
  task automatic test_div_zero();
    for (int c = 0; c <= 3; c++) begin
      drive_cycle(c <= 2, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({Busy, Load, Step, Negate, Done} !== exp_ctl(c, 1'b1, 1'b1)) begin
        errors++;
        $display("FAIL dz_ctl cyc=%0d got=%b required=%b", c, {Busy, Load, Step, Negate, Done}, exp_ctl(c, 1'b1, 1'b1));
      end
      if (c == 2) begin
        checks++;
        if (DivZero !== 1'b1) begin
          errors++;
          $display("FAIL dz_flag got=%b required=1", DivZero);
        end
      end
    end
  endtask

  // reset asserted asynchronously at Count=10, then a fresh multiply
  task automatic test_reset_mid();
    for (int c = 0; c <= 12; c++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (Count !== CW'(10)) begin
      errors++;
      $display("FAIL midrst_precount got=%0d required=10", Count);
    end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if ({Busy, Load, Step, Negate, Done, DivZero, OpLatched, SignedLatched} !== 8'b0 || Count !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got=%b count=%0d required=00000000 count=0",
               {Busy, Load, Step, Negate, Done, DivZero, OpLatched, SignedLatched}, Count);
    end
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold done=%b busy=%b required=0 0", Done, Busy);
      end
    end
    RESET = 1'b0;
    Start = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= W + 3; c++) begin
      drive_cycle(c <= W + 2, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({Busy, Load, Step, Negate, Done} !== exp_ctl(c, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL postrst_ctl cyc=%0d got=%b required=%b", c, {Busy, Load, Step, Negate, Done}, exp_ctl(c, 1'b0, 1'b0));
      end
    end
  endtask

  // mul then an immediate unsigned divide in the cycle after Done, inputs toggling in ITER
  task automatic test_back_to_back();
    for (int c = 0; c <= W + 2; c++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({Busy, Load, Step, Negate, Done} !== exp_ctl(c, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL b2b_first_ctl cyc=%0d got=%b required=%b", c, {Busy, Load, Step, Negate, Done}, exp_ctl(c, 1'b0, 1'b0));
      end
    end
    for (int c = 0; c <= W + 3; c++) begin
      if (c < 2) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      else       drive_cycle(c <= W + 2, c[0], ~c[0], 1'b1);
      checks++;
      if ({Busy, Load, Step, Negate, Done} !== exp_ctl(c, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL b2b_second_ctl cyc=%0d got=%b required=%b", c, {Busy, Load, Step, Negate, Done}, exp_ctl(c, 1'b0, 1'b0));
      end
      if (c >= 1) begin
        checks++;
        if ({OpLatched, SignedLatched} !== 2'b10) begin
          errors++;
          $display("FAIL b2b_latched cyc=%0d got=%b required=10", c, {OpLatched, SignedLatched});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_mul();
    test_signed_div();
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
